// File: rtl/cl_axil_cfg_bridge_pkg.sv
// Shared types and constants for the AXI-Lite to config-bus bridge.
package cl_axil_cfg_bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned RESP_W = 2;

    localparam logic [RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_WR,
        ST_ISSUE_RD,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/cl_axil_cfg_bridge_if.sv
// Single-beat AXI-Lite port bundle; slave = bridge side, master = host side.
interface cl_axil_cfg_bridge_if;
    import cl_axil_cfg_bridge_pkg::*;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [RESP_W-1:0] bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [RESP_W-1:0] rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

endinterface

// File: rtl/cl_axil_hold_reg.sv
// Single-entry holding register; the _c outputs bypass the incoming beat so
// the arbiter can issue in the same cycle the handshake completes.
module cl_axil_hold_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic             o_ready,
    output logic             o_avail_c,
    output logic [WIDTH-1:0] o_data_c
);

    logic             r_empty;
    logic [WIDTH-1:0] r_data;
    logic             w_take;

    assign w_take = i_valid & r_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_empty <= 1'b1;
            r_data  <= '0;
        end else if (w_take) begin
            r_empty <= 1'b0;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_empty <= 1'b1;
        end
    end

    assign o_ready   = r_empty;
    assign o_avail_c = ~r_empty | i_valid;
    assign o_data_c  = r_empty ? i_data : r_data;

endmodule

// File: rtl/cl_axil_cfg_bridge.sv
// AXI-Lite slave to pulse/ack config bus: one outstanding command, alternating
// read/write priority on ties, ack timeout reported as SLVERR.
module cl_axil_cfg_bridge
    import cl_axil_cfg_bridge_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                aclk,
    input  logic                areset,
    cl_axil_cfg_bridge_if.slave s_axil,
    output logic [ADDR_W-1:0]   cfg_addr,
    output logic [DATA_W-1:0]   cfg_wdata,
    output logic                cfg_wr,
    output logic                cfg_rd,
    input  logic                cfg_ack,
    input  logic [DATA_W-1:0]   cfg_rdata
);

    localparam int unsigned TMR_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    state_t              r_state;
    logic                r_last_was_wr;
    logic                r_is_wr;
    logic [TMR_W-1:0]    r_timer;
    logic [ADDR_W-1:0]   r_cfg_addr;
    logic [DATA_W-1:0]   r_cfg_wdata;
    logic                r_cfg_wr;
    logic                r_cfg_rd;
    logic                r_bvalid;
    logic                r_rvalid;
    logic [RESP_W-1:0]   r_bresp;
    logic [RESP_W-1:0]   r_rresp;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_aw_avail, w_w_avail, w_ar_avail;
    logic [ADDR_W-1:0]   w_aw_data, w_ar_data;
    logic [DATA_W-1:0]   w_w_data;
    logic                w_clr_wr, w_clr_rd;
    logic                w_wr_elig, w_rd_elig, w_grant_wr, w_grant_rd;
    logic                w_timeout, w_resp_done;

    assign w_clr_wr = (r_state == ST_ISSUE_WR);
    assign w_clr_rd = (r_state == ST_ISSUE_RD);

    cl_axil_hold_reg #(.WIDTH(ADDR_W)) u_aw (
        .clk(aclk), .rst(areset), .i_valid(s_axil.awvalid), .i_data(s_axil.awaddr),
        .i_clear(w_clr_wr), .o_ready(s_axil.awready), .o_avail_c(w_aw_avail), .o_data_c(w_aw_data)
    );

    cl_axil_hold_reg #(.WIDTH(DATA_W)) u_w (
        .clk(aclk), .rst(areset), .i_valid(s_axil.wvalid), .i_data(s_axil.wdata),
        .i_clear(w_clr_wr), .o_ready(s_axil.wready), .o_avail_c(w_w_avail), .o_data_c(w_w_data)
    );

    cl_axil_hold_reg #(.WIDTH(ADDR_W)) u_ar (
        .clk(aclk), .rst(areset), .i_valid(s_axil.arvalid), .i_data(s_axil.araddr),
        .i_clear(w_clr_rd), .o_ready(s_axil.arready), .o_avail_c(w_ar_avail), .o_data_c(w_ar_data)
    );

    // Ties go to the direction opposite the last one issued
    assign w_wr_elig   = w_aw_avail & w_w_avail;
    assign w_rd_elig   = w_ar_avail;
    assign w_grant_rd  = w_rd_elig & (~w_wr_elig | r_last_was_wr);
    assign w_grant_wr  = w_wr_elig & ~w_grant_rd;
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_timer == TMR_LAST);
    assign w_resp_done = (r_bvalid & s_axil.bready) | (r_rvalid & s_axil.rready);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= ST_IDLE;
            r_last_was_wr <= 1'b1;
            r_is_wr       <= 1'b0;
            r_timer       <= '0;
            r_cfg_addr    <= '0;
            r_cfg_wdata   <= '0;
            r_cfg_wr      <= 1'b0;
            r_cfg_rd      <= 1'b0;
            r_bvalid      <= 1'b0;
            r_rvalid      <= 1'b0;
            r_bresp       <= AXI_RESP_OKAY;
            r_rresp       <= AXI_RESP_OKAY;
            r_rdata       <= '0;
        end else begin
            r_cfg_wr <= 1'b0;
            r_cfg_rd <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant_wr) begin
                        r_state     <= ST_ISSUE_WR;
                        r_cfg_wr    <= 1'b1;
                        r_cfg_addr  <= w_aw_data;
                        r_cfg_wdata <= w_w_data;
                    end else if (w_grant_rd) begin
                        r_state    <= ST_ISSUE_RD;
                        r_cfg_rd   <= 1'b1;
                        r_cfg_addr <= w_ar_data;
                    end
                end
                ST_ISSUE_WR, ST_ISSUE_RD: begin
                    r_state       <= ST_WAIT;
                    r_is_wr       <= w_clr_wr;
                    r_last_was_wr <= w_clr_wr;
                    r_timer       <= '0;
                end
                ST_WAIT: begin
                    if (r_timer != TMR_MAX) r_timer <= r_timer + TMR_W'(1);
                    // Ack takes precedence over a coincident timeout
                    if (cfg_ack || w_timeout) begin
                        r_state <= ST_RESP;
                        if (r_is_wr) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= cfg_ack ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                        end else begin
                            r_rvalid <= 1'b1;
                            r_rresp  <= cfg_ack ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                            r_rdata  <= cfg_ack ? cfg_rdata : TIMEOUT_RDATA;
                        end
                    end
                end
                ST_RESP: begin
                    if (w_resp_done) begin
                        r_state  <= ST_IDLE;
                        r_bvalid <= 1'b0;
                        r_rvalid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cfg_addr      = r_cfg_addr;
    assign cfg_wdata     = r_cfg_wdata;
    assign cfg_wr        = r_cfg_wr;
    assign cfg_rd        = r_cfg_rd;
    assign s_axil.bvalid = r_bvalid;
    assign s_axil.bresp  = r_bresp;
    assign s_axil.rvalid = r_rvalid;
    assign s_axil.rresp  = r_rresp;
    assign s_axil.rdata  = r_rdata;

endmodule

// File: tb/tb_cl_axil_cfg_bridge.sv
// Directed and randomized checks of cl_axil_cfg_bridge against a transaction-level model.
module tb_cl_axil_cfg_bridge;
    import cl_axil_cfg_bridge_pkg::*;

    localparam int          T       = 8;
    localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] cfg_addr, cfg_wdata, cfg_rdata;
    logic        cfg_wr, cfg_rd, cfg_ack;

    int n_tests = 0;
    int n_fail  = 0;

    cl_axil_cfg_bridge_if bus ();

    cl_axil_cfg_bridge #(.TIMEOUT_CYCLES(T), .TIMEOUT_RDATA(TO_DATA)) dut (
        .aclk(aclk), .areset(areset), .s_axil(bus.slave),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
        .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Offer any combination of AW/W/AR beats for one cycle
    task automatic send(input bit do_aw, input bit do_w, input bit do_ar,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] ra);
        if (do_aw) chk("awready_before_beat", 32'(bus.awready), 32'd1);
        if (do_w)  chk("wready_before_beat",  32'(bus.wready),  32'd1);
        if (do_ar) chk("arready_before_beat", 32'(bus.arready), 32'd1);
        bus.awvalid = do_aw; bus.awaddr = a;
        bus.wvalid  = do_w;  bus.wdata  = d; bus.wstrb = 4'hF;
        bus.arvalid = do_ar; bus.araddr = ra;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    endtask

    // Expect an issue after exp_wait cycles, ack in WAIT cycle k (k<0: ack in
    // the issue cycle only), hold the response ready low for bp cycles.
    task automatic serve(input bit exp_wr, input logic [31:0] exp_addr, input logic [31:0] exp_data,
                         input int exp_wait, input int k, input logic [31:0] rdv, input int bp);
        int          c;
        int          bad;
        bit          got;
        bit          ok;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        c = 0;
        while (!(cfg_wr || cfg_rd) && c < 50) begin
            tick();
            c++;
        end
        chk("issue_wait", 32'(c), 32'(exp_wait));
        chk("issue_kind", {30'd0, cfg_wr, cfg_rd}, exp_wr ? 32'd2 : 32'd1);
        chk("cfg_addr", cfg_addr, exp_addr);
        if (exp_wr) chk("cfg_wdata", cfg_wdata, exp_data);

        c = 0; bad = 0; got = 1'b0;
        while (!got && c < T + 20) begin
            cfg_ack   = (c == k + 1);
            cfg_rdata = rdv;
            tick();
            c++;
            if (cfg_wr || cfg_rd) bad++;
            if (cfg_addr !== exp_addr) bad++;
            if (exp_wr && cfg_wdata !== exp_data) bad++;
            got = exp_wr ? bus.bvalid : bus.rvalid;
        end
        cfg_ack = 1'b0;

        ok        = (k >= 0) && (k < T);
        exp_resp  = ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        exp_rdata = ok ? rdv : TO_DATA;
        chk("resp_latency", 32'(c), ok ? 32'(k + 2) : 32'(T + 1));
        chk("cfg_hold_stable", 32'(bad), 32'd0);
        if (exp_wr) chk("bresp", 32'(bus.bresp), 32'(exp_resp));
        else begin
            chk("rresp", 32'(bus.rresp), 32'(exp_resp));
            chk("rdata", bus.rdata, exp_rdata);
        end

        bad = 0;
        for (int i = 0; i < bp; i++) begin
            tick();
            if (exp_wr && (bus.bvalid !== 1'b1 || bus.bresp !== exp_resp)) bad++;
            if (!exp_wr && (bus.rvalid !== 1'b1 || bus.rresp !== exp_resp || bus.rdata !== exp_rdata)) bad++;
        end
        if (bp > 0) chk("resp_backpressure_stable", 32'(bad), 32'd0);
        bus.bready = exp_wr;
        bus.rready = !exp_wr;
        tick();
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        chk("resp_valid_dropped", {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_readies"}, {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);
        chk({tag, "_valids"},  {28'd0, bus.bvalid, bus.rvalid, cfg_wr, cfg_rd}, 32'd0);
        chk({tag, "_cfg_addr"},  cfg_addr,  32'd0);
        chk({tag, "_cfg_wdata"}, cfg_wdata, 32'd0);
        chk({tag, "_rdata"},     bus.rdata, 32'd0);
        chk({tag, "_resps"},     {28'd0, bus.bresp, bus.rresp}, 32'd0);
    endtask

    initial begin
        int          k;
        int          bp;
        int          bad;
        bit          is_wr;
        logic [31:0] a, d, rv;

        areset = 1'b1;
        cfg_ack = 1'b0; cfg_rdata = '0;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.bready = 1'b0; bus.rready = 1'b0;
        repeat (3) tick();
        areset = 1'b0;
        chk_reset_state("reset");

        // Single write and single read
        send(1'b1, 1'b1, 1'b0, 32'h04, 32'h1234_5678, '0);
        serve(1'b1, 32'h04, 32'h1234_5678, 0, 1, '0, 0);
        send(1'b0, 1'b0, 1'b1, '0, '0, 32'h10);
        serve(1'b0, 32'h10, '0, 0, 0, 32'hCAFE_F00D, 0);

        // W three cycles ahead of AW
        send(1'b0, 1'b1, 1'b0, '0, 32'hA5A5_0001, '0);
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            if (bus.wready !== 1'b0 || cfg_wr !== 1'b0) bad++;
            tick();
        end
        if (bus.wready !== 1'b0 || cfg_wr !== 1'b0) bad++;
        chk("split_w_held", 32'(bad), 32'd0);
        send(1'b1, 1'b0, 1'b0, 32'h20, '0, '0);
        serve(1'b1, 32'h20, 32'hA5A5_0001, 0, 0, '0, 0);

        // Ties alternate, starting with the read
        send(1'b1, 1'b1, 1'b1, 32'h100, 32'hD1, 32'h200);
        serve(1'b0, 32'h200, '0, 0, 2, 32'h1111_2222, 0);
        send(1'b0, 1'b0, 1'b1, '0, '0, 32'h300);
        serve(1'b1, 32'h100, 32'hD1, 0, 0, '0, 0);
        send(1'b1, 1'b1, 1'b0, 32'h400, 32'hD2, '0);
        serve(1'b0, 32'h300, '0, 0, 0, 32'h3333_4444, 0);
        serve(1'b1, 32'h400, 32'hD2, 1, 3, '0, 0);

        // Timeout, late ack, coincident ack, ack during issue cycle
        send(1'b0, 1'b0, 1'b1, '0, '0, 32'h44);
        serve(1'b0, 32'h44, '0, 0, 100, 32'h5555_5555, 0);
        cfg_ack = 1'b1;
        tick();
        cfg_ack = 1'b0;
        tick();
        chk("late_ack_ignored", {28'd0, bus.bvalid, bus.rvalid, cfg_wr, cfg_rd}, 32'd0);
        send(1'b0, 1'b0, 1'b1, '0, '0, 32'h48);
        serve(1'b0, 32'h48, '0, 0, T - 1, 32'h600D_0001, 0);
        send(1'b1, 1'b1, 1'b0, 32'h4C, 32'h7777_0000, '0);
        serve(1'b1, 32'h4C, 32'h7777_0000, 0, -1, '0, 0);

        // Response backpressure
        send(1'b1, 1'b1, 1'b0, 32'h50, 32'h0BAD_CAFE, '0);
        serve(1'b1, 32'h50, 32'h0BAD_CAFE, 0, 0, '0, 5);

        // Randomized single transactions
        for (int it = 0; it < 24; it++) begin
            is_wr = 1'($urandom_range(0, 1));
            a  = $urandom();
            d  = $urandom();
            rv = $urandom();
            k  = int'($urandom_range(0, T + 2)) - 1;
            bp = int'($urandom_range(0, 3));
            if (is_wr) begin
                send(1'b1, 1'b1, 1'b0, a, d, '0);
                serve(1'b1, a, d, 0, k, rv, bp);
            end else begin
                send(1'b0, 1'b0, 1'b1, '0, '0, a);
                serve(1'b0, a, '0, 0, k, rv, bp);
            end
        end

        // Reset during WAIT with an AR beat held
        send(1'b1, 1'b1, 1'b0, 32'h60, 32'h55, '0);
        tick();
        send(1'b0, 1'b0, 1'b1, '0, '0, 32'h64);
        areset = 1'b1;
        tick();
        chk_reset_state("mid_reset");
        areset = 1'b0;
        cfg_ack = 1'b1;
        tick();
        cfg_ack = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.bvalid || bus.rvalid || cfg_wr || cfg_rd) bad++;
            tick();
        end
        chk("no_activity_after_reset", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
